afpm_seq_ctrl: RTL and testbench

Sequencing controller for the 16-bit (FP16) logarithmic approximate multiplier. Assembles byte-serial A/B operands from the pad inputs, issues one multiply per operand pair, and bypasses the multiplier for signed-zero products. Waits for completion with a timeout and returns the result byte-serially under a ready/valid handshake. It sits between the top-level pad wrapper and the multiplier core.

---
 rtl/afpm_pkg.sv | 30 +++
 rtl/afpm_out_serializer.sv | 44 ++++
 rtl/afpm_seq_ctrl.sv | 160 ++++++++++++++++
 tb/tb_afpm_seq_ctrl.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/afpm_pkg.sv
// Shared types, FP16 constants and operand helpers for the FP16 log-multiplier
// sequencing controller.
package afpm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HI     = 3'd1,
        ST_ISSUE  = 3'd2,
        ST_WAIT   = 3'd3,
        ST_OUT_LO = 3'd4,
        ST_OUT_HI = 3'd5
    } afpm_state_t;

    localparam logic [15:0] FP16_QNAN    = 16'h7E00;
    localparam logic [4:0]  FP16_EXP_MAX = 5'h1F;

    // True for +0 and -0 (magnitude bits all clear).
    function automatic logic fp16_is_zero(input logic [15:0] x);
        return (x[14:0] == 15'd0);
    endfunction

    // A zero operand lets us skip the multiplier, unless the other operand
    // is Inf/NaN: 0 x Inf must produce NaN, so those go to the core.
    function automatic logic fp16_zero_bypass(input logic [15:0] a,
                                              input logic [15:0] b);
        return (fp16_is_zero(a) && (b[14:10] != FP16_EXP_MAX)) ||
               (fp16_is_zero(b) && (a[14:10] != FP16_EXP_MAX));
    endfunction

endpackage

// File: rtl/afpm_out_serializer.sv
// Result holding register and byte-serial output stage. The controller tells
// it which byte to present next cycle; the byte stays put while the consumer
// stalls because the controller keeps requesting the same byte.
module afpm_out_serializer (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] load_data,
    input  logic        emit_lo,
    input  logic        emit_hi,
    output logic        out_valid,
    output logic [7:0]  out_byte
);

    logic [15:0] result;

    // Capture the product (or bypass / timeout value) when the controller loads it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result <= 16'h0000;
        end else if (load) begin
            result <= load_data;
        end
    end

    // Registered byte select; the low byte is forwarded from load_data on the
    // load cycle so it appears together with out_valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_byte  <= 8'h00;
        end else begin
            out_valid <= emit_lo | emit_hi;
            if (emit_lo) begin
                out_byte <= load ? load_data[7:0] : result[7:0];
            end else if (emit_hi) begin
                out_byte <= result[15:8];
            end else begin
                out_byte <= 8'h00;
            end
        end
    end

endmodule

// File: rtl/afpm_seq_ctrl.sv
// Sequencing controller for the FP16 logarithmic approximate multiplier:
// byte-serial operand assembly, multiply issue with zero bypass, bounded wait
// for completion and byte-serial result return.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | waiting for operand low bytes
// ST_HI     | low bytes held, waiting for operand high bytes
// ST_ISSUE  | operands complete; mul_start high unless zero bypass
// ST_WAIT   | waiting for mul_done, counting toward TIMEOUT
// ST_OUT_LO | presenting result[7:0] until accepted
// ST_OUT_HI | presenting result[15:8] until accepted
module afpm_seq_ctrl
    import afpm_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ena,
    input  logic        in_valid,
    input  logic [7:0]  a_byte,
    input  logic [7:0]  b_byte,
    output logic        mul_start,
    output logic [15:0] mul_a,
    output logic [15:0] mul_b,
    input  logic        mul_done,
    input  logic [15:0] mul_result,
    output logic        out_valid,
    output logic [7:0]  out_byte,
    input  logic        out_ready,
    output logic        busy,
    output logic        err
);

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    afpm_state_t state, state_next;
    logic [7:0]  cnt, cnt_next, cnt_inc;
    logic [15:0] a_next, b_next;
    logic        start_next, err_next, busy_next;
    logic        load;
    logic [15:0] load_data;
    logic        emit_lo, emit_hi;
    logic        take_byte, accept;

    assign take_byte = ena & in_valid;
    assign accept    = out_valid & out_ready;
    assign cnt_inc   = cnt + 8'd1;

    // State, operand, counter and flag registers; mul_start and busy are
    // registered from next-state so they line up with the state they describe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= 8'd0;
            mul_a     <= 16'h0000;
            mul_b     <= 16'h0000;
            mul_start <= 1'b0;
            busy      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            mul_a     <= a_next;
            mul_b     <= b_next;
            mul_start <= start_next;
            busy      <= busy_next;
            err       <= err_next;
        end
    end

    // Next-state, operand assembly, timeout counting and result selection.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        a_next     = mul_a;
        b_next     = mul_b;
        start_next = 1'b0;
        err_next   = err;
        load       = 1'b0;
        load_data  = 16'h0000;

        unique case (state)
            ST_IDLE: begin
                if (take_byte) begin
                    a_next[7:0] = a_byte;
                    b_next[7:0] = b_byte;
                    err_next    = 1'b0;
                    state_next  = ST_HI;
                end
            end
            ST_HI: begin
                if (take_byte) begin
                    a_next[15:8] = a_byte;
                    b_next[15:8] = b_byte;
                    // Decide the start pulse from the operands as they will be
                    // in ISSUE, so mul_start is high during ISSUE itself.
                    start_next   = !fp16_zero_bypass({a_byte, mul_a[7:0]},
                                                     {b_byte, mul_b[7:0]});
                    state_next   = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (fp16_zero_bypass(mul_a, mul_b)) begin
                    load       = 1'b1;
                    load_data  = {mul_a[15] ^ mul_b[15], 15'd0};
                    state_next = ST_OUT_LO;
                end else begin
                    cnt_next   = 8'd0;
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (mul_done) begin
                    load       = 1'b1;
                    load_data  = mul_result;
                    state_next = ST_OUT_LO;
                end else begin
                    cnt_next = cnt_inc;
                    if (cnt_inc == TIMEOUT_CNT) begin
                        load       = 1'b1;
                        load_data  = FP16_QNAN;
                        err_next   = 1'b1;
                        state_next = ST_OUT_LO;
                    end
                end
            end
            ST_OUT_LO: begin
                if (accept) begin
                    state_next = ST_OUT_HI;
                end
            end
            ST_OUT_HI: begin
                if (accept) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign emit_lo   = (state_next == ST_OUT_LO);
    assign emit_hi   = (state_next == ST_OUT_HI);
    assign busy_next = (state_next != ST_IDLE);

    afpm_out_serializer u_ser (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .load_data (load_data),
        .emit_lo   (emit_lo),
        .emit_hi   (emit_hi),
        .out_valid (out_valid),
        .out_byte  (out_byte)
    );

endmodule

// File: tb/tb_afpm_seq_ctrl.sv
// Bench for afpm_seq_ctrl: directed cases followed by randomized operations,
// with the bench acting as the multiplier and as the output consumer.
module tb_afpm_seq_ctrl;

    localparam int TIMEOUT = 15;

    logic        clk;
    logic        rst;
    logic        ena;
    logic        in_valid;
    logic [7:0]  a_byte;
    logic [7:0]  b_byte;
    logic        mul_start;
    logic [15:0] mul_a;
    logic [15:0] mul_b;
    logic        mul_done;
    logic [15:0] mul_result;
    logic        out_valid;
    logic [7:0]  out_byte;
    logic        out_ready;
    logic        busy;
    logic        err;

    int checks = 0;
    int errors = 0;

    logic [15:0] last_a;
    logic [15:0] last_b;

    afpm_seq_ctrl #(.TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst        (rst),
        .ena        (ena),
        .in_valid   (in_valid),
        .a_byte     (a_byte),
        .b_byte     (b_byte),
        .mul_start  (mul_start),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_done   (mul_done),
        .mul_result (mul_result),
        .out_valid  (out_valid),
        .out_byte   (out_byte),
        .out_ready  (out_ready),
        .busy       (busy),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Product of a signed zero with anything finite is a signed zero.
    function automatic logic ref_bypass(input logic [15:0] a, input logic [15:0] b);
        logic a_zero, b_zero, a_special, b_special;
        a_zero    = ((a & 16'h7FFF) == 16'h0000);
        b_zero    = ((b & 16'h7FFF) == 16'h0000);
        a_special = (((a >> 10) & 16'h001F) == 16'h001F);
        b_special = (((b >> 10) & 16'h001F) == 16'h001F);
        return (a_zero && !b_special) || (b_zero && !a_special);
    endfunction

    function automatic logic [15:0] pick_operand();
        logic [15:0] v;
        v = 16'($urandom);
        case ($urandom_range(5, 0))
            0: v = v & 16'h8000;
            1: v = (v & 16'h8000) | 16'h7C00;
            2: v = (v & 16'h83FF) | 16'h7C01;
            default: ;
        endcase
        return v;
    endfunction

    // One complete operation. done_at = WAIT cycle (1-based) in which the
    // bench pulses mul_done; 0 means the multiplier never answers.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                          input int done_at, input logic [15:0] mres,
                          input int gap, input int stall_lo, input int stall_hi);
        logic        byp;
        logic        err_exp;
        logic [15:0] exp_res;
        int          n;
        byp     = ref_bypass(a, b);
        err_exp = 1'b0;

        ena = 1'b1; in_valid = 1'b1; a_byte = a[7:0]; b_byte = b[7:0];
        tick();
        chk("lo_busy", busy, 1);
        chk("lo_err_clear", err, 0);
        chk("lo_mul_a", mul_a, {last_a[15:8], a[7:0]});
        chk("lo_mul_b", mul_b, {last_b[15:8], b[7:0]});

        for (int i = 0; i < gap; i++) begin
            if ($urandom_range(1, 0) == 1) begin
                ena = 1'b0; in_valid = 1'b1;
            end else begin
                ena = 1'b1; in_valid = 1'b0;
            end
            a_byte = 8'($urandom); b_byte = 8'($urandom);
            tick();
            chk("hi_hold_busy", busy, 1);
            chk("hi_hold_start", mul_start, 0);
            chk("hi_hold_mul_a", mul_a, {last_a[15:8], a[7:0]});
        end

        ena = 1'b1; in_valid = 1'b1; a_byte = a[15:8]; b_byte = b[15:8];
        tick();
        in_valid = 1'b0;
        last_a = a; last_b = b;
        chk("issue_start", mul_start, {31'd0, !byp});
        chk("issue_mul_a", mul_a, a);
        chk("issue_mul_b", mul_b, b);
        chk("issue_valid", out_valid, 0);

        if (byp) begin
            exp_res = {a[15] ^ b[15], 15'd0};
            tick();
            chk("byp_no_start", mul_start, 0);
        end else begin
            tick();
            chk("start_one_pulse", mul_start, 0);
            if (done_at > 0) begin
                for (int i = 1; i < done_at; i++) begin
                    chk("wait_no_valid", out_valid, 0);
                    chk("wait_busy", busy, 1);
                    mul_result = 16'($urandom);
                    tick();
                end
                exp_res    = mres;
                mul_done   = 1'b1;
                mul_result = mres;
                tick();
                mul_done   = 1'b0;
                mul_result = 16'($urandom);
            end else begin
                exp_res = 16'h7E00;
                err_exp = 1'b1;
                n = 0;
                while (out_valid !== 1'b1 && n < 4 * TIMEOUT) begin
                    tick();
                    n++;
                end
                chk("timeout_wait_cycles", n, TIMEOUT);
            end
        end

        chk("out_lo_valid", out_valid, 1);
        chk("out_lo_byte", out_byte, exp_res[7:0]);
        chk("out_lo_err", err, err_exp);

        out_ready = 1'b0;
        for (int i = 0; i < stall_lo; i++) begin
            in_valid = 1'($urandom); a_byte = 8'($urandom); b_byte = 8'($urandom);
            mul_done = 1'($urandom); mul_result = 16'($urandom);
            tick();
            chk("lo_stall_byte", out_byte, exp_res[7:0]);
            chk("lo_stall_valid", out_valid, 1);
        end
        in_valid = 1'b0; mul_done = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("out_hi_valid", out_valid, 1);
        chk("out_hi_byte", out_byte, exp_res[15:8]);

        for (int i = 0; i < stall_hi; i++) begin
            in_valid = 1'($urandom); a_byte = 8'($urandom); b_byte = 8'($urandom);
            mul_done = 1'($urandom); mul_result = 16'($urandom);
            tick();
            chk("hi_stall_byte", out_byte, exp_res[15:8]);
            chk("hi_stall_valid", out_valid, 1);
        end
        in_valid = 1'b0; mul_done = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("end_valid", out_valid, 0);
        chk("end_busy", busy, 0);
        chk("end_err", err, err_exp);
        chk("end_mul_a_held", mul_a, a);
    endtask

    initial begin
        rst = 1'b1; ena = 1'b0; in_valid = 1'b0; a_byte = 8'h00; b_byte = 8'h00;
        mul_done = 1'b0; mul_result = 16'h0000; out_ready = 1'b0;
        last_a = 16'h0000; last_b = 16'h0000;
        tick();
        tick();
        chk("rst_start", mul_start, 0);
        chk("rst_mul_a", mul_a, 0);
        chk("rst_mul_b", mul_b, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_byte", out_byte, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        rst = 1'b0;
        tick();

        // Normal multiply, done in the third WAIT cycle.
        run_op(16'h3E00, 16'h4200, 3, 16'h4480, 0, 0, 0);
        // Signed-zero bypass.
        run_op(16'h0000, 16'h4200, 0, 16'h0000, 0, 0, 0);
        run_op(16'h8000, 16'h4200, 0, 16'h0000, 0, 0, 0);
        // 0 x Inf must reach the multiplier.
        run_op(16'h0000, 16'h7C00, 1, 16'h7E00, 0, 0, 0);
        // No answer from the multiplier: qNaN and sticky err.
        run_op(16'h1234, 16'h5678, 0, 16'h0000, 0, 0, 0);
        // Next operation clears err; long consumer stall in OUT_LO.
        run_op(16'h3E00, 16'h4200, 3, 16'h4480, 1, 5, 2);
        // Done on the same edge the counter would time out: done wins.
        run_op(16'h3C00, 16'hC000, TIMEOUT, 16'hC000, 2, 0, 0);

        // ena low in IDLE drops bytes; mul_done in IDLE is ignored.
        ena = 1'b0; in_valid = 1'b1; a_byte = 8'hAA; b_byte = 8'h55;
        tick();
        chk("ena_low_busy", busy, 0);
        chk("ena_low_mul_a", mul_a, last_a);
        in_valid = 1'b0; ena = 1'b1;
        mul_done = 1'b1; mul_result = 16'h1111;
        tick();
        mul_done = 1'b0;
        chk("idle_done_busy", busy, 0);
        chk("idle_done_valid", out_valid, 0);

        // Reset while waiting on the multiplier; late mul_done is discarded.
        ena = 1'b1; in_valid = 1'b1; a_byte = 8'h00; b_byte = 8'h00;
        tick();
        a_byte = 8'h3C; b_byte = 8'h40;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        chk("pre_rst_busy", busy, 1);
        rst = 1'b1;
        #1;
        chk("async_rst_busy", busy, 0);
        chk("async_rst_mul_a", mul_a, 0);
        chk("async_rst_mul_b", mul_b, 0);
        chk("async_rst_valid", out_valid, 0);
        chk("async_rst_start", mul_start, 0);
        tick();
        rst = 1'b0;
        last_a = 16'h0000; last_b = 16'h0000;
        mul_done = 1'b1; mul_result = 16'h4480;
        tick();
        mul_done = 1'b0;
        chk("post_rst_valid", out_valid, 0);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_byte", out_byte, 0);
        chk("post_rst_err", err, 0);

        // Randomized operations, back to back.
        for (int k = 0; k < 40; k++) begin
            int d;
            d = ($urandom_range(4, 0) == 0) ? 0 : int'($urandom_range(TIMEOUT, 1));
            run_op(pick_operand(), pick_operand(), d, 16'($urandom),
                   int'($urandom_range(2, 0)), int'($urandom_range(3, 0)),
                   int'($urandom_range(3, 0)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
